// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single registered-read block RAM port
// between NUM_REQS req/ack requesters, one access per three cycles.
module ram_arbiter #(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8,
  parameter int NUM_REQS  = 2
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic [NUM_REQS-1:0]           in_req,
  input  logic [NUM_REQS-1:0]           in_write,
  input  logic [NUM_REQS*ADDR_BITS-1:0] in_addr,
  input  logic [NUM_REQS*WORD_BITS-1:0] in_data,
  output logic [NUM_REQS-1:0]           out_grant,
  output logic [NUM_REQS-1:0]           out_ack,
  output logic [WORD_BITS-1:0]          out_data,
  output logic                          out_ram_read_ena,
  output logic                          out_ram_write_ena,
  output logic [ADDR_BITS-1:0]          out_ram_addr,
  output logic [WORD_BITS-1:0]          out_ram_data,
  input  logic [WORD_BITS-1:0]          in_ram_data
);

  localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  wr_q, wr_d;
  logic [NUM_REQS-1:0]   grant_q, grant_d;
  logic [NUM_REQS-1:0]   ack_q, ack_d;
  logic [WORD_BITS-1:0]  rdata_q, rdata_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic [ADDR_BITS-1:0]  raddr_q, raddr_d;
  logic [WORD_BITS-1:0]  wdata_q, wdata_d;

  logic [ADDR_BITS-1:0]  addr_a [NUM_REQS];
  logic [WORD_BITS-1:0]  data_a [NUM_REQS];
  logic [NUM_REQS-1:0]   elig;
  logic                  found;
  logic [PW-1:0]         win;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
    assign addr_a[g] = in_addr[g*ADDR_BITS +: ADDR_BITS];
    assign data_a[g] = in_data[g*WORD_BITS +: WORD_BITS];
  end

  // A requester acked this cycle sits out one evaluation.
  always_comb begin
    elig  = in_req & ~ack_q;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NUM_REQS; k++) begin
      int          idx;
      logic [PW-1:0] ci;
      idx = (int'(ptr_q) + k) % NUM_REQS;
      ci  = PW'(idx);
      if (!found && elig[ci]) begin
        found = 1'b1;
        win   = ci;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    grant_d = grant_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    raddr_d = '0;
    wdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d        = win;
          wr_d         = in_write[win];
          grant_d      = '0;
          grant_d[win] = 1'b1;
          ren_d        = ~in_write[win];
          wen_d        = in_write[win];
          raddr_d      = addr_a[win];
          wdata_d      = data_a[win];
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        state_d = WAIT;
      end
      WAIT: begin
        rdata_d = wr_q ? '0 : in_ram_data;
        ack_d   = grant_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQS - 1);
      wr_q    <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      raddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_grant         = grant_q;
  assign out_ack           = ack_q;
  assign out_data          = rdata_q;
  assign out_ram_read_ena  = ren_q;
  assign out_ram_write_ena = wen_q;
  assign out_ram_addr      = raddr_q;
  assign out_ram_data      = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two- and three-requester instances,
// each backed by a registered-read RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req, wr, grant, ack;
  logic [5:0]  addr;
  logic [15:0] wdat;
  logic [7:0]  odata, ram_wd, ram_rd;
  logic [2:0]  ram_addr;
  logic        ren, wen;

  logic [2:0]  req3, wr3, grant3, ack3;
  logic [8:0]  addr3;
  logic [23:0] wdat3;
  logic [7:0]  odata3, ram_wd3, ram_rd3;
  logic [2:0]  ram_addr3;
  logic        ren3, wen3;

  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  mem  [8];
  logic [7:0]  mem3 [8];

  logic [24:0] outs2;
  assign outs2 = {grant, ack, odata, ren, wen, ram_addr, ram_wd};

  ram_arbiter #(.ADDR_BITS(3), .WORD_BITS(8), .NUM_REQS(2)) u_dut2 (
    .in_clk(clk), .in_rst(rst), .in_req(req), .in_write(wr),
    .in_addr(addr), .in_data(wdat), .out_grant(grant), .out_ack(ack),
    .out_data(odata), .out_ram_read_ena(ren), .out_ram_write_ena(wen),
    .out_ram_addr(ram_addr), .out_ram_data(ram_wd), .in_ram_data(ram_rd)
  );

  ram_arbiter #(.ADDR_BITS(3), .WORD_BITS(8), .NUM_REQS(3)) u_dut3 (
    .in_clk(clk), .in_rst(rst), .in_req(req3), .in_write(wr3),
    .in_addr(addr3), .in_data(wdat3), .out_grant(grant3), .out_ack(ack3),
    .out_data(odata3), .out_ram_read_ena(ren3), .out_ram_write_ena(wen3),
    .out_ram_addr(ram_addr3), .out_ram_data(ram_wd3), .in_ram_data(ram_rd3)
  );

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wen) mem[ram_addr] <= ram_wd;
    ram_rd <= ren ? mem[ram_addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (wen3) mem3[ram_addr3] <= ram_wd3;
    ram_rd3 <= ren3 ? mem3[ram_addr3] : 8'h00;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0; wr = '0; addr = '0; wdat = '0;
    req3 = '0; wr3 = '0; addr3 = '0; wdat3 = '0;
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 8'hA5;
    tick();
    ld_en = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_outs", 32'(outs2), 0);
    chk("rst_outs3", 32'({grant3, ack3, ren3, wen3, odata3}), 0);

    // read addr 3
    req = 2'b01; wr = 2'b00; addr[2:0] = 3'd3;
    tick();
    chk("t1_ren", 32'(ren), 1);
    chk("t1_addr", 32'(ram_addr), 3);
    chk("t1_gnt", 32'(grant), 32'h1);
    tick();
    chk("t1_wait_ren", 32'(ren), 0);
    chk("t1_wait_gnt", 32'(grant), 32'h1);
    chk("t1_wait_ack", 32'(ack), 0);
    tick();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_data", 32'(odata), 32'hA5);
    chk("t1_gnt0", 32'(grant), 0);
    req = 2'b00;
    tick();
    chk("t1_ack_low", 32'(ack), 0);
    chk("t1_hold", 32'(odata), 32'hA5);

    // write then read back
    req = 2'b10; wr = 2'b10; addr[5:3] = 3'd5; wdat[15:8] = 8'h3C;
    tick();
    chk("t2_wen", 32'(wen), 1);
    chk("t2_ren", 32'(ren), 0);
    chk("t2_addr", 32'(ram_addr), 5);
    chk("t2_wd", 32'(ram_wd), 32'h3C);
    chk("t2_gnt", 32'(grant), 32'h2);
    tick();
    chk("t2_wen_off", 32'(wen), 0);
    tick();
    chk("t2_ack", 32'(ack), 32'h2);
    chk("t2_data", 32'(odata), 0);
    req = 2'b01; wr = 2'b00; addr[2:0] = 3'd5;
    tick();
    chk("t2r_ren", 32'(ren), 1);
    chk("t2r_addr", 32'(ram_addr), 5);
    chk("t2r_gnt", 32'(grant), 32'h1);
    tick();
    tick();
    chk("t2r_ack", 32'(ack), 32'h1);
    chk("t2r_data", 32'(odata), 32'h3C);
    req = 2'b00;
    tick();

    // both held: 0,1,0,1
    do_reset();
    req = 2'b11; wr = 2'b00; addr = {3'd5, 3'd3};
    for (int c = 1; c <= 12; c++) begin
      logic [1:0] eg, ea;
      tick();
      ea = '0;
      eg = '0;
      if (c % 3 == 0) ea = (c % 6 == 3) ? 2'b01 : 2'b10;
      else eg = (((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_ack_c%0d", c), 32'(ack), 32'(ea));
      chk($sformatf("t3_gnt_c%0d", c), 32'(grant), 32'(eg));
      if (ea == 2'b01) chk($sformatf("t3_d_c%0d", c), 32'(odata), 32'hA5);
      if (ea == 2'b10) chk($sformatf("t3_d_c%0d", c), 32'(odata), 32'h3C);
    end
    req = 2'b00;

    // fields change after grant
    do_reset();
    req = 2'b01; wr = 2'b00; addr[2:0] = 3'd3;
    tick();
    chk("t4_ren", 32'(ren), 1);
    chk("t4_addr", 32'(ram_addr), 3);
    req = 2'b00; addr[2:0] = 3'd5;
    tick();
    tick();
    chk("t4_ack", 32'(ack), 32'h1);
    chk("t4_data", 32'(odata), 32'hA5);
    tick();
    chk("t4_ack_low", 32'(ack), 0);
    chk("t4_gnt", 32'(grant), 0);
    chk("t4_ren_idle", 32'(ren), 0);

    // reset during ACCESS
    req = 2'b01; wr = 2'b00; addr[2:0] = 3'd3;
    tick();
    chk("t5_ren", 32'(ren), 1);
    #1 rst = 1'b1;
    #1 chk("t5_async", 32'(outs2), 0);
    tick();
    rst = 1'b0;
    req = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t5_noack_%0d", c), 32'(ack), 0);
    end
    req = 2'b11; addr = {3'd5, 3'd3};
    tick();
    chk("t5_gnt0", 32'(grant), 32'h1);
    tick();
    tick();
    chk("t5_ack0", 32'(ack), 32'h1);
    req = 2'b00;
    tick();

    // three requesters, requester 1 writes
    do_reset();
    req3 = 3'b111; wr3 = 3'b010;
    addr3 = {3'd2, 3'd1, 3'd0}; wdat3 = 24'h33_22_11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("t6_excl_c%0d", c), 32'(ren3 & wen3), 0);
      if (c % 3 == 1) begin
        int k;
        k = ((c - 1) / 3) % 3;
        chk($sformatf("t6_gnt_c%0d", c), 32'(grant3), 32'(1) << k);
        chk($sformatf("t6_ren_c%0d", c), 32'(ren3), (k != 1) ? 1 : 0);
        chk($sformatf("t6_wen_c%0d", c), 32'(wen3), (k == 1) ? 1 : 0);
      end
    end
    req3 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
